// File: rtl/axi_line_master.sv
// Cache-line AXI4 master: turns one 128-bit line request from the bus controller
// into a 4-beat, 32-bit INCR read or write burst and reports completion.
module axi_line_master #(
    parameter int AXI_ID_W = 4,
    parameter int AXI_ID   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bc_valid_req_i,
    input  logic                bc_rw_i,
    input  logic [31:0]         bc_addr_i,
    input  logic [127:0]        bc_data_i,
    output logic [127:0]        axi_data_o,
    output logic                axi_rd_over_o,
    output logic                axi_wr_over_o,
    output logic                bus_err_o,
    output logic                core_WAIT_o,
    output logic [AXI_ID_W-1:0] m_axi_arid,
    output logic [31:0]         m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [AXI_ID_W-1:0] m_axi_rid,
    input  logic [31:0]         m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    output logic [AXI_ID_W-1:0] m_axi_awid,
    output logic [31:0]         m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [31:0]         m_axi_wdata,
    output logic [3:0]          m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [AXI_ID_W-1:0] m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [127:0]   line_q, line_d;
    logic [127:0]   rd_line_q, rd_line_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           rd_over_q, rd_over_d;
    logic           wr_over_q, wr_over_d;
    logic           bus_err_q, bus_err_d;
    logic           unused_inputs;

    assign unused_inputs = ^{m_axi_rid, m_axi_bid, bc_addr_i[3:0]};

    assign m_axi_arid    = AXI_ID_W'(AXI_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'd3;
    assign m_axi_arsize  = 3'd2;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state_q == S_AR);
    assign m_axi_rready  = (state_q == S_R);

    assign m_axi_awid    = AXI_ID_W'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'd3;
    assign m_axi_awsize  = 3'd2;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state_q == S_AW);

    // Write payload comes straight from the captured line, so it stays stable during stalls.
    assign m_axi_wdata   = line_q[{cnt_q, 5'b0} +: 32];
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = (cnt_q == 2'd3);
    assign m_axi_wvalid  = (state_q == S_W);
    assign m_axi_bready  = (state_q == S_B);

    assign axi_data_o    = rd_line_q;
    assign axi_rd_over_o = rd_over_q;
    assign axi_wr_over_o = wr_over_q;
    assign bus_err_o     = bus_err_q;
    assign core_WAIT_o   = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        line_d    = line_q;
        rd_line_d = rd_line_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rd_over_d = 1'b0;
        wr_over_d = 1'b0;
        bus_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bc_valid_req_i) begin
                    addr_d  = {bc_addr_i[31:4], 4'b0000};
                    line_d  = bc_data_i;
                    cnt_d   = 2'd0;
                    err_d   = 1'b0;
                    state_d = bc_rw_i ? S_AR : S_AW;
                end
            end
            S_AR: begin
                if (m_axi_arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (m_axi_rvalid) begin
                    line_d[{cnt_q, 5'b0} +: 32] = m_axi_rdata;
                    // A misplaced or missing RLAST is reported but the burst still runs 4 beats.
                    err_d = err_q | (m_axi_rresp != 2'b00) | (m_axi_rlast != (cnt_q == 2'd3));
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        rd_line_d = line_d;
                        rd_over_d = 1'b1;
                        bus_err_d = err_d;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_AW: begin
                if (m_axi_awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (m_axi_wready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    wr_over_d = 1'b1;
                    bus_err_d = (m_axi_bresp != 2'b00);
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            line_q    <= '0;
            rd_line_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_over_q <= 1'b0;
            wr_over_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            rd_line_q <= rd_line_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rd_over_q <= rd_over_d;
            wr_over_q <= wr_over_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_axi_line_master.sv
// Bench for axi_line_master: a bench-driven AXI slave plus a scoreboard of
// expected line results, burst addresses, write beats and completion cycles.
module tb_axi_line_master;

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
        logic         err;
        int           n;
        int           exp_cyc;
    } item_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bc_valid_req_i = 1'b0;
    logic         bc_rw_i = 1'b0;
    logic [31:0]  bc_addr_i = '0;
    logic [127:0] bc_data_i = '0;
    logic [127:0] axi_data_o;
    logic         axi_rd_over_o, axi_wr_over_o, bus_err_o, core_WAIT_o;
    logic [3:0]   m_axi_arid, m_axi_awid;
    logic [31:0]  m_axi_araddr, m_axi_awaddr, m_axi_wdata;
    logic [7:0]   m_axi_arlen, m_axi_awlen;
    logic [2:0]   m_axi_arsize, m_axi_awsize;
    logic [1:0]   m_axi_arburst, m_axi_awburst;
    logic         m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_wlast;
    logic         m_axi_rready, m_axi_bready;
    logic [3:0]   m_axi_wstrb;
    logic         m_axi_arready = 1'b1;
    logic         m_axi_awready = 1'b1;
    logic [3:0]   m_axi_rid = 4'h0;
    logic [3:0]   m_axi_bid = 4'h0;
    logic [31:0]  m_axi_rdata = '0;
    logic [1:0]   m_axi_rresp = 2'b00;
    logic         m_axi_rlast = 1'b0;
    logic         m_axi_rvalid = 1'b0;
    logic         m_axi_wready = 1'b0;
    logic [1:0]   m_axi_bresp = 2'b00;
    logic         m_axi_bvalid = 1'b0;

    // Slave configuration, owned by the main thread.
    logic [31:0]  rd_words [4];
    int           err_beat = 4;
    int           last_beat = 3;
    int           stall_beat = 4;
    int           stall_len = 0;

    // Slave progress, owned by the posedge monitor.
    int           cycle_cnt = 0;
    int           rbeat = 0;
    int           wbeat = 0;
    int           stall_cnt = 0;
    logic         rd_pending = 1'b0;
    logic         b_pending = 1'b0;
    int           ar_count = 0;
    int           aw_count = 0;
    int           over_count = 0;

    item_t        sb_q [$];
    int           checks = 0;
    int           errors = 0;

    axi_line_master dut (
        .clk(clk), .rst(rst),
        .bc_valid_req_i(bc_valid_req_i), .bc_rw_i(bc_rw_i),
        .bc_addr_i(bc_addr_i), .bc_data_i(bc_data_i),
        .axi_data_o(axi_data_o), .axi_rd_over_o(axi_rd_over_o),
        .axi_wr_over_o(axi_wr_over_o), .bus_err_o(bus_err_o), .core_WAIT_o(core_WAIT_o),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    // Track handshakes at the edge where they take effect; values read here are pre-edge.
    always @(posedge clk) begin
        cycle_cnt = cycle_cnt + 1;
        if (rst) begin
            rd_pending = 1'b0;
            b_pending  = 1'b0;
            rbeat      = 0;
            wbeat      = 0;
            stall_cnt  = 0;
        end else begin
            if (m_axi_arvalid && m_axi_arready) begin
                ar_count   = ar_count + 1;
                rd_pending = 1'b1;
                rbeat      = 0;
            end else if (m_axi_rvalid && m_axi_rready) begin
                if (rbeat == 3) begin
                    rd_pending = 1'b0;
                    rbeat      = 0;
                end else begin
                    rbeat = rbeat + 1;
                end
            end
            if (m_axi_awvalid && m_axi_awready) begin
                aw_count  = aw_count + 1;
                stall_cnt = 0;
            end
            if (m_axi_wvalid && !m_axi_wready) begin
                stall_cnt = stall_cnt + 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (wbeat == 3) begin
                    b_pending = 1'b1;
                    wbeat     = 0;
                end else begin
                    wbeat = wbeat + 1;
                end
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pending = 1'b0;
            end
            if (axi_rd_over_o || axi_wr_over_o) begin
                over_count = over_count + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cycle_cnt);
        end
    endtask

    task automatic driveSlave();
        m_axi_rvalid = rd_pending;
        m_axi_rdata  = rd_words[rbeat];
        m_axi_rresp  = (rd_pending && rbeat == err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast  = rd_pending && (rbeat == last_beat);
        m_axi_wready = !(wbeat == stall_beat && stall_cnt < stall_len);
        m_axi_bvalid = b_pending;
        m_axi_bresp  = 2'b00;
    endtask

    task automatic scoreboardCheck();
        item_t it;
        if (m_axi_arvalid || m_axi_awvalid || (m_axi_wvalid && m_axi_wready)
            || axi_rd_over_o || axi_wr_over_o) begin
            checkOutput("sb_has_item", (sb_q.size() > 0), 1'b1);
        end
        if (sb_q.size() == 0) return;
        it = sb_q[0];
        if (m_axi_arvalid) checkOutput("araddr", m_axi_araddr, it.addr);
        if (m_axi_awvalid) checkOutput("awaddr", m_axi_awaddr, it.addr);
        if (m_axi_wvalid && m_axi_wready) begin
            checkOutput("wdata", m_axi_wdata, it.data[wbeat*32 +: 32]);
            checkOutput("wlast", m_axi_wlast, (wbeat == 3));
        end
        if (axi_rd_over_o || axi_wr_over_o) begin
            it = sb_q.pop_front();
            checkOutput("over_kind", axi_rd_over_o, it.rw);
            checkOutput("over_cycle", cycle_cnt - it.n + 1, it.exp_cyc);
            checkOutput("bus_err", bus_err_o, it.err);
            checkOutput("wait_low_at_over", core_WAIT_o, 1'b0);
            if (it.rw) checkOutput("read_line", axi_data_o, it.data);
        end
    endtask

    // One cycle: slave outputs and scoreboard at the falling edge, then return #1 after the rising edge.
    task automatic step();
        @(negedge clk);
        driveSlave();
        scoreboardCheck();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [127:0] wline,
                                 input logic exp_err, input int exp_cyc);
        item_t it;
        it.rw      = rw;
        it.addr    = addr & 32'hFFFF_FFF0;
        it.data    = rw ? {rd_words[3], rd_words[2], rd_words[1], rd_words[0]} : wline;
        it.err     = exp_err;
        it.n       = cycle_cnt + 1;
        it.exp_cyc = exp_cyc;
        sb_q.push_back(it);
        bc_valid_req_i = 1'b1;
        bc_rw_i        = rw;
        bc_addr_i      = addr;
        bc_data_i      = rw ? 128'h0 : wline;
        step();
        bc_valid_req_i = 1'b0;
    endtask

    task automatic waitDone(input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            step();
            if (axi_rd_over_o || axi_wr_over_o) seen = 1'b1;
        end
        checkOutput("completion_seen", seen, 1'b1);
    endtask

    task automatic setWords(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
        rd_words[0] = w0;
        rd_words[1] = w1;
        rd_words[2] = w2;
        rd_words[3] = w3;
    endtask

    initial begin
        logic seen;
        int   ar0;
        int   ov0;

        setWords(32'h0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        checkOutput("rst_arvalid", m_axi_arvalid, 1'b0);
        checkOutput("rst_awvalid", m_axi_awvalid, 1'b0);
        checkOutput("rst_wvalid", m_axi_wvalid, 1'b0);
        checkOutput("rst_rready", m_axi_rready, 1'b0);
        checkOutput("rst_bready", m_axi_bready, 1'b0);
        checkOutput("rst_data", axi_data_o, 128'h0);
        checkOutput("rst_pulses", {axi_rd_over_o, axi_wr_over_o, bus_err_o}, 3'b000);
        checkOutput("rst_wait", core_WAIT_o, 1'b0);
        checkOutput("rst_araddr", m_axi_araddr, 32'h0);
        checkOutput("rst_awaddr", m_axi_awaddr, 32'h0);
        rst = 1'b0;
        step();

        // Zero-wait read; also the fixed burst attributes.
        setWords(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        applyStimulus(1'b1, 32'h8000_0014, 128'h0, 1'b0, 6);
        checkOutput("arvalid_cycle1", m_axi_arvalid, 1'b1);
        checkOutput("wait_high", core_WAIT_o, 1'b1);
        checkOutput("ar_attrs", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid}, {8'd3, 3'd2, 2'b01, 4'd0});
        waitDone(20);
        checkOutput("read1_line", axi_data_o, 128'h44444444_33333333_22222222_11111111);
        step();

        // Write with wready low on the second beat for two cycles.
        stall_beat = 1;
        stall_len  = 2;
        applyStimulus(1'b0, 32'h0000_1000,
                      128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b0, 9);
        checkOutput("aw_attrs", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wstrb}, {8'd3, 3'd2, 2'b01, 4'hF});
        waitDone(30);
        checkOutput("data_held_after_write", axi_data_o, 128'h44444444_33333333_22222222_11111111);
        step();
        stall_beat = 4;
        stall_len  = 0;

        // SLVERR on the first beat.
        setWords(32'hA5A50001, 32'hA5A50002, 32'hA5A50003, 32'hA5A50004);
        err_beat = 0;
        applyStimulus(1'b1, 32'h0000_2040, 128'h0, 1'b1, 6);
        waitDone(20);
        step();
        err_beat = 4;

        // Early RLAST on beat 2, none on beat 4.
        setWords(32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0003, 32'h0BAD0004);
        last_beat = 1;
        applyStimulus(1'b1, 32'h0000_3008, 128'h0, 1'b1, 6);
        waitDone(20);
        step();
        last_beat = 3;

        // Plain zero-wait write.
        applyStimulus(1'b0, 32'h0000_4000,
                      128'h44440004_33330003_22220002_11110001, 1'b0, 7);
        waitDone(20);
        step();

        // A strobe during R is ignored; a request in the over cycle is taken at once.
        setWords(32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003);
        ar0 = ar_count;
        applyStimulus(1'b1, 32'h0000_5000, 128'h0, 1'b0, 6);
        step();
        step();
        bc_valid_req_i = 1'b1;
        bc_rw_i        = 1'b1;
        bc_addr_i      = 32'h0000_6000;
        step();
        bc_valid_req_i = 1'b0;
        waitDone(20);
        checkOutput("single_ar", ar_count, ar0 + 1);
        setWords(32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210);
        applyStimulus(1'b1, 32'h0000_7010, 128'h0, 1'b0, 6);
        checkOutput("arvalid_after_over", m_axi_arvalid, 1'b1);
        waitDone(20);
        checkOutput("two_ar", ar_count, ar0 + 2);
        step();

        // Reset while the second write beat is being presented.
        applyStimulus(1'b0, 32'h0000_8000,
                      128'h87654321_0FEDCBA9_55556666_77778888, 1'b0, 7);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (wbeat == 1) seen = 1'b1;
        end
        checkOutput("reached_beat2", seen, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rst_mid_wvalid", m_axi_wvalid, 1'b0);
        checkOutput("rst_mid_wait", core_WAIT_o, 1'b0);
        sb_q.delete();
        ov0 = over_count;
        repeat (4) step();
        checkOutput("no_over_after_rst", over_count, ov0);

        // A normal read after the interrupted write.
        setWords(32'hFACE0000, 32'hFACE1111, 32'hFACE2222, 32'hFACE3333);
        applyStimulus(1'b1, 32'h0000_9000, 128'h0, 1'b0, 6);
        waitDone(20);
        checkOutput("post_rst_line", axi_data_o, 128'hFACE3333_FACE2222_FACE1111_FACE0000);
        step();
        step();
        checkOutput("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
